alua_mp_seq: RTL
================

# alua_mp_seq

Multi-precision arithmetic sequencer for the Gumnut datapath. Takes two NBYTES-wide operands and one arithmetic op, then runs them byte by byte, least-significant byte first, through a single shared 8-bit `alua` instance. The carry/borrow from each byte is held in a register and fed to the next byte. The block sits beside the core's ALU as a coprocessor-style unit: the issuing logic starts it and waits for `done`. The result is returned in full with final carry, overflow and zero flags.

## Interface
Parameters:
- `NBYTES`, default 4: operand width in bytes; legal range 2..16.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high; one clock.
- `start`  in  1  request pulse; sampled only when accepting (IDLE or DONE).
- `op`  in  2  00 add, 01 addc, 10 sub, 11 subc (same encoding as `alua` sel).
- `cin`  in  1  carry/borrow in for byte 0; used only by addc/subc.
- `a`  in  8*NBYTES  operand A, latched on start.
- `b`  in  8*NBYTES  operand B, latched on start.
- `busy`  out  1  high while bytes are being processed.
- `done`  out  1  one-cycle pulse; result and flags valid.
- `result`  out  8*NBYTES  result; held until the next accepted start.
- `cout`  out  1  carry (add) or borrow (sub) out of the top byte.
- `vout`  out  1  signed overflow of the top byte.
- `zero`  out  1  1 when all result bits are 0.

## Operation
- States:
  - IDLE: waits for a request.
  - RUN: processes one byte per cycle.
  - DONE: one cycle that asserts `done`.
- IDLE, start=1:
  - latch `a`, `b`, `op`, `cin`;
  - byte index := 0;
  - carry register := `cin` if op[0]=1, else 0;
  - go to RUN.
- RUN, byte i:
  - `alua` A = a[8i+7:8i], B = b[8i+7:8i].
  - sel = latched op for i=0. For i>0, sel = {op[1],1'b1}: addc for add/addc, subc for sub/subc.
  - `alua` cin = carry register.
  - At the clock edge:
    - result[8i+7:8i] := out;
    - carry register := `alua` cout;
    - i := i+1.
  - On the last byte (i=NBYTES-1): also capture cout and vout, then go to DONE.
- DONE:
  - `done`=1; `zero` reflects `result`.
  - Next state is RUN if start=1 (back-to-back; same latch as IDLE), else IDLE.
- `start` in RUN is ignored; no queuing.
- Arithmetic: carry/borrow semantics are exactly those of `alua`. Chaining addc/subc across bytes gives a two's-complement NBYTES-wide add/subtract. `vout` is valid for the full-width signed operation.
- Reset, including mid-operation:
  - state := IDLE; index := 0;
  - `result`, `cout`, `vout`, `zero`, `busy`, `done` := 0;
  - a sequence in progress is discarded and no `done` is issued.
- `result`, `cout`, `vout` and `zero` change only at the RUN edges and at reset. Byte writes are visible on `result` during RUN; consumers sample only on `done`.

## Timing
- start sampled at edge k → `busy`=1 in cycles k+1 .. k+NBYTES → `done`=1 in cycle k+NBYTES+1 only.
- Latency from start to `done` is NBYTES+1 cycles.
- Throughput is one operation per NBYTES+1 cycles when start is held or re-pulsed in DONE.
- `busy` and `done` are never high in the same cycle.
- All outputs are registered. The `alua` path is combinational within one cycle: operand byte mux → `alua` → result/carry registers.

## Structure
- `alua_pkg`: op encoding constants (OP_ADD, OP_ADDC, OP_SUB, OP_SUBC) and the state enum (S_IDLE, S_RUN, S_DONE).
- One sub-module: the existing `alua`, instantiated once.
- Index counter: $clog2(NBYTES) bits.
- Operand byte selection is an indexed part-select of the latched operands.

## Test plan
All values below use NBYTES=4.
- add, a=0x000000FF, b=0x00000001 → result=0x00000100, cout=0, vout=0, zero=0; `done` exactly 5 cycles after start; `busy` high for 4 cycles.
- add, a=0xFFFFFFFF, b=0x00000001 → result=0x00000000, cout=1, zero=1. Repeat with addc, cin=1, a=b=0 → result=0x00000001.
- sub, a=0x00000000, b=0x00000001 → result=0xFFFFFFFF, cout=1 (borrow). sub, a=0x80000000, b=1 → result=0x7FFFFFFF, vout=1.
- add, a=0x7FFFFFFF, b=1 → result=0x80000000, vout=1, cout=0.
- start pulsed in cycles 2 and 3 of RUN → ignored: one `done` only, result unchanged by the second request. start held high → back-to-back ops with `done` every 5 cycles.
- rst asserted in the second RUN cycle → next cycle: IDLE, all outputs 0, no `done` follows. A fresh start then completes normally.

Source files
------------

// File: rtl/alua_pkg.sv
// Shared encodings for the 8-bit ALU slice and the multi-precision sequencer built on it.
package alua_pkg;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_ADDC = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_SUBC = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/alua.sv
// 8-bit add/sub slice with carry/borrow in and out plus signed overflow.
module alua
    import alua_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [1:0] sel,
    input  logic       cin,
    output logic [7:0] out,
    output logic       cout,
    output logic       vout
);
    logic [8:0] ext;

    always_comb begin
        ext = 9'd0;
        case (sel)
            OP_ADD:  ext = {1'b0, a} + {1'b0, b};
            OP_ADDC: ext = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            OP_SUB:  ext = {1'b0, a} - {1'b0, b};
            default: ext = {1'b0, a} - {1'b0, b} - {8'd0, cin};
        endcase
        out  = ext[7:0];
        // bit 8 is the carry for adds and the borrow for subtracts
        cout = ext[8];
        vout = sel[1] ? ((a[7] != b[7]) && (out[7] != a[7]))
                      : ((a[7] == b[7]) && (out[7] != a[7]));
    end
endmodule

// File: rtl/alua_mp_seq.sv
// Multi-precision add/sub sequencer: runs NBYTES-wide operands LSB first through one alua.
//   state  | meaning
//   S_IDLE | waiting for start
//   S_RUN  | one byte per cycle, carry chained through carry_q
//   S_DONE | done pulse; start here re-launches back-to-back
module alua_mp_seq
    import alua_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic                cin,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] result,
    output logic                cout,
    output logic                vout,
    output logic                zero
);
    localparam int W     = 8 * NBYTES;
    localparam int IDX_W = $clog2(NBYTES);

    state_t           state, state_nxt;
    logic [W-1:0]     a_q, b_q, result_nxt;
    logic [1:0]       op_q, byte_sel;
    logic             carry_q, accept, last_byte;
    logic [IDX_W-1:0] idx;
    logic [7:0]       byte_a, byte_b, byte_out;
    logic             byte_cout, byte_vout;

    assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
    assign last_byte = (idx == IDX_W'(NBYTES - 1));
    assign byte_a    = a_q[8*idx +: 8];
    assign byte_b    = b_q[8*idx +: 8];
    // upper bytes always chain the carry/borrow regardless of the requested op
    assign byte_sel  = (idx == '0) ? op_q : {op_q[1], 1'b1};

    alua u_alua (
        .a    (byte_a),
        .b    (byte_b),
        .sel  (byte_sel),
        .cin  (carry_q),
        .out  (byte_out),
        .cout (byte_cout),
        .vout (byte_vout)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last_byte) state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        result_nxt             = result;
        result_nxt[8*idx +: 8] = byte_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == S_RUN);
            done  <= (state_nxt == S_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            carry_q <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            vout    <= 1'b0;
            zero    <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            carry_q <= op[0] & cin;
            idx     <= '0;
        end else if (state == S_RUN) begin
            result  <= result_nxt;
            carry_q <= byte_cout;
            idx     <= idx + 1'b1;
            if (last_byte) begin
                idx  <= '0;
                cout <= byte_cout;
                vout <= byte_vout;
                zero <= (result_nxt == '0);
            end
        end
    end
endmodule
